// File: rtl/mskaes_req_arbiter.sv
// Round-robin scheduler that shares one masked AES core between NREQ requesters.
// Only enables and mux selects are produced here; no share data passes through this block.
module mskaes_req_arbiter #(
   parameter int NREQ   = 2,
   parameter int LAT    = 71,
   parameter int MARGIN = 4,
   parameter int CW     = 7
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NREQ-1:0]         req_valid_i,
   output logic [NREQ-1:0]         req_ready_o,
   output logic [$clog2(NREQ)-1:0] grant_sel_o,
   output logic                    core_valid_in_o,
   input  logic                    core_ready_i,
   input  logic                    core_cipher_valid_i,
   output logic                    out_reg_en_o,
   output logic                    out_reg_clr_o,
   output logic [NREQ-1:0]         rsp_valid_o,
   input  logic [NREQ-1:0]         rsp_ready_i,
   output logic                    busy_o,
   output logic [1:0]              err_o,
   input  logic                    clr_err_i
);
   localparam int              SW       = $clog2(NREQ);
   localparam logic [CW-1:0]   LAT_C    = CW'(LAT);
   localparam logic [CW-1:0]   TMO_C    = CW'(LAT + MARGIN);
   localparam logic [SW:0]     NREQ_C   = (SW+1)'(NREQ);
   localparam logic [SW-1:0]   LAST_RST = SW'(NREQ - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_ERR} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic [SW-1:0]   last_grant_q;
   logic [SW-1:0]   owner_q;
   logic [SW-1:0]   grant_sel_q;
   logic [NREQ-1:0] rsp_valid_q;
   logic [1:0]      err_q;
   logic [1:0]      err_d;

   logic [SW:0]     cand_sum [NREQ];
   logic [SW-1:0]   cand_idx [NREQ];
   logic [NREQ-1:0] cand_hit;
   logic [NREQ-1:0] owner_onehot;
   logic [SW-1:0]   winner;
   logic            any_req;

   logic in_idle, in_run, in_hold, in_err, cv;
   logic grant_fire, result_ok, result_early, timeout, consume;

   // Candidate gi is the requester gi+1 positions after the last grant, wrapped mod NREQ.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_rr
      assign cand_sum[gi]     = {1'b0, last_grant_q} + (SW+1)'(gi + 1);
      assign cand_idx[gi]     = (cand_sum[gi] >= NREQ_C) ? SW'(cand_sum[gi] - NREQ_C)
                                                         : cand_sum[gi][SW-1:0];
      assign cand_hit[gi]     = req_valid_i[cand_idx[gi]];
      assign owner_onehot[gi] = (owner_q == SW'(gi));
      assign req_ready_o[gi]  = grant_fire && (winner == SW'(gi));
   end

   always_comb begin
      winner  = cand_idx[0];
      any_req = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (cand_hit[i]) begin
            winner  = cand_idx[i];
            any_req = 1'b1;
         end
      end
   end

   assign in_idle = (state_q == S_IDLE);
   assign in_run  = (state_q == S_RUN);
   assign in_hold = (state_q == S_HOLD);
   assign in_err  = (state_q == S_ERR);
   assign cv      = core_cipher_valid_i;

   // A stray cipher_valid in IDLE takes priority over starting a new job.
   assign grant_fire   = in_idle && any_req && core_ready_i && !cv;
   assign result_ok    = in_run && cv && (cnt_q >= LAT_C);
   assign result_early = in_run && cv && (cnt_q < LAT_C);
   assign timeout      = in_run && !cv && (cnt_q >= TMO_C);
   assign consume      = in_hold && |(rsp_ready_i & owner_onehot);

   assign core_valid_in_o = grant_fire;
   assign grant_sel_o     = grant_fire ? winner : grant_sel_q;
   assign out_reg_en_o    = result_ok;
   assign out_reg_clr_o   = in_err || (in_hold && (consume || cv));
   assign rsp_valid_o     = rsp_valid_q;
   assign busy_o          = !in_idle;
   assign err_o           = err_q;

   // In ERR a clear beats a coincident fault; elsewhere a new fault survives the clear.
   always_comb begin
      err_d = clr_err_i ? 2'b00 : err_q;
      if (!(in_err && clr_err_i)) begin
         if (result_early || timeout) err_d[0] = 1'b1;
         if (cv && !in_run)           err_d[1] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         last_grant_q <= LAST_RST;
         owner_q      <= '0;
         grant_sel_q  <= '0;
         rsp_valid_q  <= '0;
         err_q        <= '0;
      end else begin
         err_q <= err_d;
         case (state_q)
            S_IDLE: begin
               if (cv) begin
                  state_q <= S_ERR;
               end else if (grant_fire) begin
                  last_grant_q <= winner;
                  owner_q      <= winner;
                  grant_sel_q  <= winner;
                  cnt_q        <= CW'(1);
                  state_q      <= S_RUN;
               end
            end
            S_RUN: begin
               if (cnt_q != '1) cnt_q <= cnt_q + CW'(1);
               if (result_ok) begin
                  rsp_valid_q <= owner_onehot;
                  state_q     <= S_HOLD;
               end else if (result_early || timeout) begin
                  state_q <= S_ERR;
               end
            end
            S_HOLD: begin
               if (cv) begin
                  rsp_valid_q <= '0;
                  state_q     <= S_ERR;
               end else if (consume) begin
                  rsp_valid_q <= '0;
                  state_q     <= S_IDLE;
               end
            end
            S_ERR: begin
               rsp_valid_q <= '0;
               if (clr_err_i) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(req_ready_o));
   a_rsp_onehot:   assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rsp_valid_o));
   a_err_flagged:  assert property (@(posedge clk_i) disable iff (rst_i) in_err |-> (err_q != 2'b00));

endmodule

// File: tb/tb_mskaes_req_arbiter.sv
// Scoreboarded random bench for mskaes_req_arbiter: a transaction-level model predicts
// grants, loads, consumes and error codes; a negedge monitor pops and compares them.
module tb_mskaes_req_arbiter;
   localparam int NREQ   = 2;
   localparam int LAT    = 71;
   localparam int MARGIN = 4;
   localparam int CW     = 7;

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
   logic [0:0]      grant_sel;
   logic            core_valid_in, core_ready, core_cipher_valid;
   logic            out_reg_en, out_reg_clr, busy, clr_err;
   logic [1:0]      err;

   always #5 clk = ~clk;

   mskaes_req_arbiter #(.NREQ(NREQ), .LAT(LAT), .MARGIN(MARGIN), .CW(CW)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .grant_sel_o(grant_sel),
      .core_valid_in_o(core_valid_in), .core_ready_i(core_ready),
      .core_cipher_valid_i(core_cipher_valid),
      .out_reg_en_o(out_reg_en), .out_reg_clr_o(out_reg_clr),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .busy_o(busy), .err_o(err), .clr_err_i(clr_err)
   );

   int checks   = 0;
   int failures = 0;
   int txn_no   = 0;

   int         grant_q[$];
   int         load_q[$];
   int         consume_q[$];
   logic [1:0] err_q[$];

   int              model_last;
   logic [NREQ-1:0] exp_rsp  = '0;
   logic [1:0]      prev_err = 2'b00;
   bit              mon_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Round robin: first requesting index after the previous winner, wrapping.
   function automatic int model_winner(input logic [NREQ-1:0] mask);
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (model_last + k) % NREQ;
         if (mask[idx]) return idx;
      end
      return -1;
   endfunction

   // Monitor: samples on the falling edge, away from input changes and state updates.
   always @(negedge clk) begin
      if (mon_en) begin
         int w;
         chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
         if (rst) exp_rsp = '0;

         if (core_valid_in || (req_ready != '0)) begin
            if (grant_q.size() == 0) begin
               chk("unexpected_grant", {29'd0, core_valid_in, req_ready}, 32'd0);
            end else begin
               w = grant_q.pop_front();
               chk("grant_req_ready", 32'(req_ready), 32'(onehot(w)));
               chk("grant_sel", 32'(grant_sel), 32'(w));
               chk("grant_core_valid", 32'(core_valid_in), 32'd1);
            end
         end

         if (out_reg_en) begin
            if (load_q.size() == 0) begin
               chk("unexpected_load", 32'(out_reg_en), 32'd0);
            end else begin
               w = load_q.pop_front();
               exp_rsp = onehot(w);
            end
         end

         if (out_reg_clr && (err == 2'b00)) begin
            if (consume_q.size() == 0) begin
               chk("unexpected_clr", 32'(out_reg_clr), 32'd0);
            end else begin
               w = consume_q.pop_front();
               chk("consume_rsp_valid", 32'(rsp_valid), 32'(onehot(w)));
               exp_rsp = '0;
            end
         end

         if (err !== prev_err) begin
            if (err_q.size() == 0) begin
               chk("unexpected_err", 32'(err), 32'(prev_err));
            end else begin
               chk("err_code", 32'(err), 32'(err_q.pop_front()));
            end
            prev_err = err;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_grant(input logic [NREQ-1:0] mask, input int stall, output int w);
      req_valid  = mask;
      core_ready = 1'b0;
      repeat (stall) tick();
      w          = model_winner(mask);
      model_last = w;
      grant_q.push_back(w);
      core_ready = 1'b1;
      tick();
      req_valid  = '0;
      core_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic clear_err();
      repeat (2) tick();
      err_q.push_back(2'b00);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("idle_after_clr", 32'(busy), 32'd0);
   endtask

   task automatic txn_normal(input logic [NREQ-1:0] mask, input int stall, input int hold);
      int w;
      issue_grant(mask, stall, w);
      $display("txn %0d normal mask=%b winner=%0d hold=%0d", txn_no++, mask, w, hold);
      chk("busy_run", 32'(busy), 32'd1);
      repeat (LAT - 1) tick();
      load_q.push_back(w);
      core_cipher_valid = 1'b1;
      tick();
      core_cipher_valid = 1'b0;
      for (int i = 0; i < hold; i++) begin
         rsp_ready = NREQ'($urandom) & ~onehot(w);
         tick();
      end
      consume_q.push_back(w);
      rsp_ready = onehot(w) | (NREQ'($urandom) & ~onehot(w));
      tick();
      rsp_ready = '0;
   endtask

   task automatic txn_timeout(input logic [NREQ-1:0] mask);
      int w;
      issue_grant(mask, 0, w);
      $display("txn %0d timeout mask=%b winner=%0d", txn_no++, mask, w);
      repeat (LAT + MARGIN - 1) tick();
      chk("err_before_timeout", 32'(err), 32'd0);
      err_q.push_back(2'b01);
      tick();
      chk("err_timeout", 32'(err), 32'd1);
      chk("busy_err", 32'(busy), 32'd1);
      clear_err();
   endtask

   task automatic txn_early(input logic [NREQ-1:0] mask, input int at_cnt);
      int w;
      issue_grant(mask, 0, w);
      $display("txn %0d early mask=%b winner=%0d cnt=%0d", txn_no++, mask, w, at_cnt);
      repeat (at_cnt - 1) tick();
      err_q.push_back(2'b01);
      core_cipher_valid = 1'b1;
      tick();
      core_cipher_valid = 1'b0;
      chk("err_early", 32'(err), 32'd1);
      clear_err();
   endtask

   task automatic txn_spurious();
      $display("txn %0d spurious cipher_valid in idle", txn_no++);
      err_q.push_back(2'b10);
      core_cipher_valid = 1'b1;
      tick();
      core_cipher_valid = 1'b0;
      chk("err_spurious", 32'(err), 32'd2);
      chk("busy_spurious", 32'(busy), 32'd1);
      clear_err();
   endtask

   task automatic txn_reset(input logic [NREQ-1:0] mask);
      int w;
      issue_grant(mask, 0, w);
      $display("txn %0d reset at cnt=30 mask=%b winner=%0d", txn_no++, mask, w);
      repeat (29) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_last = NREQ - 1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_grant_sel", 32'(grant_sel), 32'd0);
      chk("rst_mealy", {28'd0, req_ready, core_valid_in, out_reg_en}, 32'd0);
      chk("rst_clr", 32'(out_reg_clr), 32'd0);
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; rsp_ready = '0; core_ready = 1'b0;
      core_cipher_valid = 1'b0; clr_err = 1'b0;
      model_last = NREQ - 1;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_grant_sel", 32'(grant_sel), 32'd0);
      chk("reset_mealy", {28'd0, req_ready, core_valid_in, out_reg_en}, 32'd0);
      mon_en = 1'b1;

      txn_normal(2'b01, 0, 0);
      repeat (4) txn_normal(2'b11, 0, 0);
      txn_normal(2'b01, 1, 20);
      txn_timeout(2'b01);
      txn_spurious();
      txn_early(2'b10, 50);
      txn_reset(2'b11);
      txn_normal(2'b11, 0, 1);

      for (int n = 0; n < 14; n++) begin
         int kind;
         logic [NREQ-1:0] m;
         kind = $urandom_range(0, 9);
         m    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         case (kind)
            0:       txn_timeout(m);
            1:       txn_early(m, $urandom_range(1, LAT - 1));
            2:       txn_spurious();
            3:       txn_reset(m);
            default: txn_normal(m, $urandom_range(0, 2), $urandom_range(0, 6));
         endcase
      end

      repeat (3) tick();
      chk("grant_q_drained", 32'(grant_q.size()), 32'd0);
      chk("load_q_drained", 32'(load_q.size()), 32'd0);
      chk("consume_q_drained", 32'(consume_q.size()), 32'd0);
      chk("err_q_drained", 32'(err_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: actual=timeout required=completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
